// File: rtl/ledpanel_wr_arbiter.sv
// ledpanel_wr_arbiter: merges two pixel-write requesters and a full-frame fill
// engine onto one registered framebuffer write port (one write per cycle).
// Requesters are served round-robin in IDLE; FILL owns the port for exactly
// FB_DEPTH cycles, sweeping every address with the colour captured at start.
module ledpanel_wr_arbiter #(
  parameter int CHAINED = 1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [15:0] s0_addr,
  input  logic [23:0] s0_wdat,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [15:0] s1_addr,
  input  logic [23:0] s1_wdat,
  input  logic        fill_start,
  input  logic [23:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        oob_drop,
  output logic        ctrl_en,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat
);

  // 17 bits so that a 16-panel chain (65536 words) still compares correctly.
  localparam logic [16:0] FB_DEPTH_W = 17'(CHAINED * 4096);
  localparam logic [15:0] LAST_ADDR  = 16'(CHAINED * 4096 - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] color_q, color_d;
  logic        last_q, last_d;      // 1: s1 was granted most recently
  logic        en_q, en_d;
  logic [15:0] addr_q, addr_d;
  logic [23:0] wdat_q, wdat_d;
  logic        oob_q, oob_d;
  logic        done_q, done_d;

  logic        hs0, hs1;
  logic [15:0] sel_addr;
  logic [23:0] sel_wdat;
  logic        sel_in_range;

  // State register.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state: fill_start only matters in IDLE; FILL ends after the last address.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fill_start) state_d = FILL;
      FILL: if (cnt_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: readies are combinational, round-robin on ties, held low in FILL and reset.
  always_comb begin
    fill_busy = (state_q == FILL);
    s0_ready  = ctrl_rst_n && (state_q == IDLE) && s0_valid && (!s1_valid || last_q);
    s1_ready  = ctrl_rst_n && (state_q == IDLE) && s1_valid && (!s0_valid || !last_q);
  end

  assign hs0          = s0_valid && s0_ready;
  assign hs1          = s1_valid && s1_ready;
  assign sel_addr     = hs0 ? s0_addr : s1_addr;
  assign sel_wdat     = hs0 ? s0_wdat : s1_wdat;
  assign sel_in_range = ({1'b0, sel_addr} < FB_DEPTH_W);

  // Datapath next-state: fill writes own the port in FILL, else the granted requester.
  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    oob_d   = 1'b0;
    done_d  = 1'b0;

    if (hs0)      last_d = 1'b0;
    else if (hs1) last_d = 1'b1;

    if (state_q == FILL) begin
      en_d   = 1'b1;
      addr_d = cnt_q;
      wdat_d = color_q;
      done_d = (cnt_q == LAST_ADDR);
      // Saturate at the last address; the next fill clears the counter anyway.
      if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 16'd1;
    end else begin
      if (fill_start) begin
        cnt_d   = 16'd0;
        color_d = fill_color;
      end
      if (hs0 || hs1) begin
        if (sel_in_range) begin
          en_d   = 1'b1;
          addr_d = sel_addr;
          wdat_d = sel_wdat;
        end else begin
          oob_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers; the grant pointer resets to s1 so s0 wins the first tie.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      color_q <= 24'd0;
      en_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdat_q  <= 24'd0;
      oob_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      oob_q   <= oob_d;
      done_q  <= done_d;
    end
  end

  assign ctrl_en   = en_q;
  assign ctrl_addr = addr_q;
  assign ctrl_wdat = wdat_q;
  assign oob_drop  = oob_q;
  assign fill_done = done_q;

endmodule

// File: tb/tb_ledpanel_wr_arbiter.sv
// Directed bench for ledpanel_wr_arbiter (CHAINED=1, 4096-word framebuffer).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_ledpanel_wr_arbiter;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst_n;
  logic        s0_valid, s0_ready;
  logic [15:0] s0_addr;
  logic [23:0] s0_wdat;
  logic        s1_valid, s1_ready;
  logic [15:0] s1_addr;
  logic [23:0] s1_wdat;
  logic        fill_start;
  logic [23:0] fill_color;
  logic        fill_busy, fill_done, oob_drop;
  logic        ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;

  int errors = 0;
  int checks = 0;

  ledpanel_wr_arbiter #(.CHAINED(1)) dut (
    .ctrl_clk   (ctrl_clk),
    .ctrl_rst_n (ctrl_rst_n),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s0_addr    (s0_addr),
    .s0_wdat    (s0_wdat),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .s1_addr    (s1_addr),
    .s1_wdat    (s1_wdat),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .oob_drop   (oob_drop),
    .ctrl_en    (ctrl_en),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdat  (ctrl_wdat)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_en"},   32'(ctrl_en),   32'h0);
    chk({tag, "_addr"}, 32'(ctrl_addr), 32'h0);
    chk({tag, "_wdat"}, 32'(ctrl_wdat), 32'h0);
    chk({tag, "_busy"}, 32'(fill_busy), 32'h0);
    chk({tag, "_done"}, 32'(fill_done), 32'h0);
    chk({tag, "_oob"},  32'(oob_drop),  32'h0);
  endtask

  initial begin
    logic exp_s1;
    ctrl_rst_n = 1'b0;
    s0_valid = 1'b0; s0_addr = 16'h0; s0_wdat = 24'h0;
    s1_valid = 1'b0; s1_addr = 16'h0; s1_wdat = 24'h0;
    fill_start = 1'b0; fill_color = 24'h0;

    // Reset state; readies stay low even with a valid present.
    tick(); tick();
    s0_valid = 1'b1;
    #1;
    chk_outs_zero("rst");
    chk("rst_s0_ready", 32'(s0_ready), 32'h0);
    s0_valid = 1'b0;

    // Release reset and serve s1 alone.
    tick();
    ctrl_rst_n = 1'b1;
    s1_valid = 1'b1; s1_addr = 16'h0005; s1_wdat = 24'h3F003F;
    #1;
    chk("s1only_ready1", 32'(s1_ready), 32'h1);
    chk("s1only_ready0", 32'(s0_ready), 32'h0);
    tick();
    s1_valid = 1'b0;
    chk("s1only_en",   32'(ctrl_en),   32'h1);
    chk("s1only_addr", 32'(ctrl_addr), 32'h0005);
    chk("s1only_wdat", 32'(ctrl_wdat), 32'h3F003F);
    tick();
    chk("idle_en",        32'(ctrl_en),   32'h0);
    chk("idle_addr_hold", 32'(ctrl_addr), 32'h0005);
    chk("idle_wdat_hold", 32'(ctrl_wdat), 32'h3F003F);

    // Both valid continuously: last grant was s1, so s0,s1,s0,... follow.
    s0_valid = 1'b1; s0_addr = 16'h0010; s0_wdat = 24'h111111;
    s1_valid = 1'b1; s1_addr = 16'h0020; s1_wdat = 24'h222222;
    exp_s1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_s0_ready", i), 32'(s0_ready), 32'(!exp_s1));
      chk($sformatf("rr%0d_s1_ready", i), 32'(s1_ready), 32'(exp_s1));
      tick();
      chk($sformatf("rr%0d_en", i),   32'(ctrl_en),   32'h1);
      chk($sformatf("rr%0d_addr", i), 32'(ctrl_addr), exp_s1 ? 32'h0020 : 32'h0010);
      chk($sformatf("rr%0d_wdat", i), 32'(ctrl_wdat), exp_s1 ? 32'h222222 : 32'h111111);
      exp_s1 = !exp_s1;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
    chk("rr_end_en", 32'(ctrl_en), 32'h0);

    // Out-of-range write: handshake, no write, one oob pulse.
    s0_valid = 1'b1; s0_addr = 16'h1000; s0_wdat = 24'hDEADBE;
    #1;
    chk("oob_ready", 32'(s0_ready), 32'h1);
    tick();
    s0_valid = 1'b0;
    chk("oob_en",    32'(ctrl_en),   32'h0);
    chk("oob_pulse", 32'(oob_drop),  32'h1);
    chk("oob_addr",  32'(ctrl_addr), 32'h0020);
    tick();
    chk("oob_clear", 32'(oob_drop), 32'h0);

    // Highest in-range address is written.
    s0_valid = 1'b1; s0_addr = 16'h0FFF; s0_wdat = 24'h010203;
    tick();
    s0_valid = 1'b0;
    chk("top_en",   32'(ctrl_en),   32'h1);
    chk("top_addr", 32'(ctrl_addr), 32'h0FFF);
    chk("top_oob",  32'(oob_drop),  32'h0);

    // fill_start coinciding with an s0 handshake at 0x0001.
    s0_valid = 1'b1; s0_addr = 16'h0001; s0_wdat = 24'hABCDEF;
    fill_start = 1'b1; fill_color = 24'h0A0B0C;
    #1;
    chk("fs_s0_ready", 32'(s0_ready), 32'h1);
    tick();
    // Requesters keep asking and fill_start/colour keep changing: all ignored.
    fill_color = 24'h123456;
    s1_valid = 1'b1; s1_addr = 16'h0020;
    chk("fs_busy", 32'(fill_busy), 32'h1);
    chk("fs_en",   32'(ctrl_en),   32'h1);
    chk("fs_addr", 32'(ctrl_addr), 32'h0001);
    chk("fs_wdat", 32'(ctrl_wdat), 32'hABCDEF);
    #1;
    chk("fs_stall0", 32'(s0_ready), 32'h0);
    chk("fs_stall1", 32'(s1_ready), 32'h0);
    for (int k = 0; k < 4096; k++) begin
      tick();
      if (k == 10) fill_start = 1'b0;
      chk($sformatf("fill%0d_en", k),   32'(ctrl_en),   32'h1);
      chk($sformatf("fill%0d_addr", k), 32'(ctrl_addr), 32'(k));
      chk($sformatf("fill%0d_wdat", k), 32'(ctrl_wdat), 32'h0A0B0C);
      chk($sformatf("fill%0d_done", k), 32'(fill_done), 32'(k == 4095));
      chk($sformatf("fill%0d_busy", k), 32'(fill_busy), 32'(k != 4095));
      if (k != 4095) begin
        chk($sformatf("fill%0d_rdy0", k), 32'(s0_ready), 32'h0);
        chk($sformatf("fill%0d_rdy1", k), 32'(s1_ready), 32'h0);
      end
    end
    // Back in IDLE: last grant was s0, so s1 wins the tie.
    chk("post_fill_rdy0", 32'(s0_ready), 32'h0);
    chk("post_fill_rdy1", 32'(s1_ready), 32'h1);
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
    chk("post_fill_en",   32'(ctrl_en),   32'h0);
    chk("post_fill_done", 32'(fill_done), 32'h0);

    // Second fill, aborted by reset at address 0x0200.
    fill_start = 1'b1; fill_color = 24'h556677;
    tick();
    fill_start = 1'b0;
    chk("fill2_busy", 32'(fill_busy), 32'h1);
    for (int k = 0; k <= 16'h0200; k++) tick();
    chk("fill2_addr", 32'(ctrl_addr), 32'h0200);
    chk("fill2_wdat", 32'(ctrl_wdat), 32'h556677);
    ctrl_rst_n = 1'b0;
    #1;
    chk_outs_zero("abort");
    tick(); tick();
    chk_outs_zero("abort_hold");

    // After release, first tie goes to s0 and writes with latency 1.
    ctrl_rst_n = 1'b1;
    s0_valid = 1'b1; s0_addr = 16'h0033; s0_wdat = 24'h445566;
    s1_valid = 1'b1; s1_addr = 16'h0044; s1_wdat = 24'h778899;
    #1;
    chk("rel_rdy0", 32'(s0_ready), 32'h1);
    chk("rel_rdy1", 32'(s1_ready), 32'h0);
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("rel_en",   32'(ctrl_en),   32'h1);
    chk("rel_addr", 32'(ctrl_addr), 32'h0033);
    chk("rel_wdat", 32'(ctrl_wdat), 32'h445566);
    chk("rel_done", 32'(fill_done), 32'h0);
    tick();
    chk("rel_idle_en", 32'(ctrl_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
